// File: rtl/reservation_station.sv
// Unified reservation station: buffers dispatched ops, resolves operands from the
// ALU/LSB common data buses and issues the lowest-index ready entry each cycle.
module reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int RS_WIDTH  = 4,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 Dis_flag,
  input  logic [5:0]           Dis_op,
  input  logic [31:0]          Dis_imm,
  input  logic [31:0]          Dis_PC,
  input  logic [ROB_WIDTH-1:0] Dis_ROB_idx,
  input  logic                 Dis_R1,
  input  logic                 Dis_R2,
  input  logic [31:0]          Dis_V1,
  input  logic [31:0]          Dis_V2,
  input  logic                 ALU_cdb_flag,
  input  logic [ROB_WIDTH-1:0] ALU_cdb_ROB_idx,
  input  logic [31:0]          ALU_cdb_value,
  input  logic                 LSB_cdb_flag,
  input  logic [ROB_WIDTH-1:0] LSB_cdb_ROB_idx,
  input  logic [31:0]          LSB_cdb_value,
  output logic [RS_WIDTH-1:0]  RS_put_idx,
  output logic                 RS_full,
  output logic                 ALU_issue_flag,
  output logic [5:0]           ALU_op,
  output logic [31:0]          ALU_V1,
  output logic [31:0]          ALU_V2,
  output logic [31:0]          ALU_imm,
  output logic [31:0]          ALU_PC,
  output logic [ROB_WIDTH-1:0] ALU_ROB_idx
);

  logic                 r_busy [RS_SIZE];
  logic [5:0]           r_op   [RS_SIZE];
  logic [31:0]          r_imm  [RS_SIZE];
  logic [31:0]          r_pc   [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_rob  [RS_SIZE];
  logic                 r_r1   [RS_SIZE];
  logic [31:0]          r_v1   [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_q1   [RS_SIZE];
  logic                 r_r2   [RS_SIZE];
  logic [31:0]          r_v2   [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_q2   [RS_SIZE];

  logic                 r_issue;
  logic [5:0]           r_alu_op;
  logic [31:0]          r_alu_v1;
  logic [31:0]          r_alu_v2;
  logic [31:0]          r_alu_imm;
  logic [31:0]          r_alu_pc;
  logic [ROB_WIDTH-1:0] r_alu_rob;

  logic                 w_full;
  logic [RS_WIDTH-1:0]  w_put_idx;
  logic                 w_cand;
  logic [RS_WIDTH-1:0]  w_cand_idx;
  logic                 w_dis_r1;
  logic                 w_dis_r2;
  logic [31:0]          w_dis_v1;
  logic [31:0]          w_dis_v2;

  // Descending scans so the last hit is the lowest index.
  always_comb begin
    w_full     = 1'b1;
    w_put_idx  = '0;
    w_cand     = 1'b0;
    w_cand_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_full    = 1'b0;
        w_put_idx = RS_WIDTH'(i);
      end
      if (r_busy[i] && r_r1[i] && r_r2[i]) begin
        w_cand     = 1'b1;
        w_cand_idx = RS_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_dis_r1 = Dis_R1;
    w_dis_v1 = Dis_V1;
    w_dis_r2 = Dis_R2;
    w_dis_v2 = Dis_V2;
    if (!Dis_R1) begin
      if (ALU_cdb_flag && ALU_cdb_ROB_idx == Dis_V1[ROB_WIDTH-1:0]) begin
        w_dis_r1 = 1'b1;
        w_dis_v1 = ALU_cdb_value;
      end else if (LSB_cdb_flag && LSB_cdb_ROB_idx == Dis_V1[ROB_WIDTH-1:0]) begin
        w_dis_r1 = 1'b1;
        w_dis_v1 = LSB_cdb_value;
      end
    end
    if (!Dis_R2) begin
      if (ALU_cdb_flag && ALU_cdb_ROB_idx == Dis_V2[ROB_WIDTH-1:0]) begin
        w_dis_r2 = 1'b1;
        w_dis_v2 = ALU_cdb_value;
      end else if (LSB_cdb_flag && LSB_cdb_ROB_idx == Dis_V2[ROB_WIDTH-1:0]) begin
        w_dis_r2 = 1'b1;
        w_dis_v2 = LSB_cdb_value;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_busy[i] <= 1'b0;
        r_op[i]   <= '0;
        r_imm[i]  <= '0;
        r_pc[i]   <= '0;
        r_rob[i]  <= '0;
        r_r1[i]   <= 1'b0;
        r_v1[i]   <= '0;
        r_q1[i]   <= '0;
        r_r2[i]   <= 1'b0;
        r_v2[i]   <= '0;
        r_q2[i]   <= '0;
      end
      r_issue   <= 1'b0;
      r_alu_op  <= '0;
      r_alu_v1  <= '0;
      r_alu_v2  <= '0;
      r_alu_imm <= '0;
      r_alu_pc  <= '0;
      r_alu_rob <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < RS_SIZE; i++) r_busy[i] <= 1'b0;
        r_issue <= 1'b0;
      end else begin
        r_issue <= w_cand;
        if (w_cand) begin
          r_alu_op           <= r_op[w_cand_idx];
          r_alu_v1           <= r_v1[w_cand_idx];
          r_alu_v2           <= r_v2[w_cand_idx];
          r_alu_imm          <= r_imm[w_cand_idx];
          r_alu_pc           <= r_pc[w_cand_idx];
          r_alu_rob          <= r_rob[w_cand_idx];
          r_busy[w_cand_idx] <= 1'b0;
        end
        // Wakeup only touches busy entries, so it never collides with allocation.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && !r_r1[i]) begin
            if (ALU_cdb_flag && ALU_cdb_ROB_idx == r_q1[i]) begin
              r_r1[i] <= 1'b1;
              r_v1[i] <= ALU_cdb_value;
            end else if (LSB_cdb_flag && LSB_cdb_ROB_idx == r_q1[i]) begin
              r_r1[i] <= 1'b1;
              r_v1[i] <= LSB_cdb_value;
            end
          end
          if (r_busy[i] && !r_r2[i]) begin
            if (ALU_cdb_flag && ALU_cdb_ROB_idx == r_q2[i]) begin
              r_r2[i] <= 1'b1;
              r_v2[i] <= ALU_cdb_value;
            end else if (LSB_cdb_flag && LSB_cdb_ROB_idx == r_q2[i]) begin
              r_r2[i] <= 1'b1;
              r_v2[i] <= LSB_cdb_value;
            end
          end
        end
        if (Dis_flag && !w_full) begin
          r_busy[w_put_idx] <= 1'b1;
          r_op[w_put_idx]   <= Dis_op;
          r_imm[w_put_idx]  <= Dis_imm;
          r_pc[w_put_idx]   <= Dis_PC;
          r_rob[w_put_idx]  <= Dis_ROB_idx;
          r_r1[w_put_idx]   <= w_dis_r1;
          r_v1[w_put_idx]   <= w_dis_v1;
          r_q1[w_put_idx]   <= Dis_R1 ? '0 : Dis_V1[ROB_WIDTH-1:0];
          r_r2[w_put_idx]   <= w_dis_r2;
          r_v2[w_put_idx]   <= w_dis_v2;
          r_q2[w_put_idx]   <= Dis_R2 ? '0 : Dis_V2[ROB_WIDTH-1:0];
        end
      end
    end
  end

  assign RS_full        = w_full;
  assign RS_put_idx     = w_full ? '0 : w_put_idx;
  assign ALU_issue_flag = r_issue;
  assign ALU_op         = r_alu_op;
  assign ALU_V1         = r_alu_v1;
  assign ALU_V2         = r_alu_v2;
  assign ALU_imm        = r_alu_imm;
  assign ALU_PC         = r_alu_pc;
  assign ALU_ROB_idx    = r_alu_rob;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: ready path, wakeup, bypass, fill/priority,
// flush, freeze and asynchronous reset, with hand-computed expectations.
module tb_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_in;
  logic        Dis_flag;
  logic [5:0]  Dis_op;
  logic [31:0] Dis_imm;
  logic [31:0] Dis_PC;
  logic [3:0]  Dis_ROB_idx;
  logic        Dis_R1;
  logic        Dis_R2;
  logic [31:0] Dis_V1;
  logic [31:0] Dis_V2;
  logic        ALU_cdb_flag;
  logic [3:0]  ALU_cdb_ROB_idx;
  logic [31:0] ALU_cdb_value;
  logic        LSB_cdb_flag;
  logic [3:0]  LSB_cdb_ROB_idx;
  logic [31:0] LSB_cdb_value;
  logic [3:0]  RS_put_idx;
  logic        RS_full;
  logic        ALU_issue_flag;
  logic [5:0]  ALU_op;
  logic [31:0] ALU_V1;
  logic [31:0] ALU_V2;
  logic [31:0] ALU_imm;
  logic [31:0] ALU_PC;
  logic [3:0]  ALU_ROB_idx;

  int n_vec = 0;
  int n_err = 0;

  reservation_station #(.RS_SIZE(16), .RS_WIDTH(4), .ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .Dis_flag(Dis_flag), .Dis_op(Dis_op), .Dis_imm(Dis_imm), .Dis_PC(Dis_PC),
    .Dis_ROB_idx(Dis_ROB_idx), .Dis_R1(Dis_R1), .Dis_R2(Dis_R2),
    .Dis_V1(Dis_V1), .Dis_V2(Dis_V2),
    .ALU_cdb_flag(ALU_cdb_flag), .ALU_cdb_ROB_idx(ALU_cdb_ROB_idx), .ALU_cdb_value(ALU_cdb_value),
    .LSB_cdb_flag(LSB_cdb_flag), .LSB_cdb_ROB_idx(LSB_cdb_ROB_idx), .LSB_cdb_value(LSB_cdb_value),
    .RS_put_idx(RS_put_idx), .RS_full(RS_full), .ALU_issue_flag(ALU_issue_flag),
    .ALU_op(ALU_op), .ALU_V1(ALU_V1), .ALU_V2(ALU_V2), .ALU_imm(ALU_imm),
    .ALU_PC(ALU_PC), .ALU_ROB_idx(ALU_ROB_idx)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Drive one dispatch across a single edge, then drop the request and any CDB.
  task automatic dis(input logic r1, input logic [31:0] v1, input logic r2,
                     input logic [31:0] v2, input logic [3:0] rob);
    Dis_flag    = 1'b1;
    Dis_op      = 6'h21;
    Dis_imm     = 32'h1000 + 32'(rob);
    Dis_PC      = 32'h8000 + 32'(rob);
    Dis_ROB_idx = rob;
    Dis_R1      = r1;
    Dis_V1      = v1;
    Dis_R2      = r2;
    Dis_V2      = v2;
    step();
    Dis_flag     = 1'b0;
    ALU_cdb_flag = 1'b0;
    LSB_cdb_flag = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    Dis_flag = 1'b0; Dis_op = '0; Dis_imm = '0; Dis_PC = '0; Dis_ROB_idx = '0;
    Dis_R1 = 1'b0; Dis_R2 = 1'b0; Dis_V1 = '0; Dis_V2 = '0;
    ALU_cdb_flag = 1'b0; ALU_cdb_ROB_idx = '0; ALU_cdb_value = '0;
    LSB_cdb_flag = 1'b0; LSB_cdb_ROB_idx = '0; LSB_cdb_value = '0;
    #3;
    chk("rst_flag", ALU_issue_flag, 0);
    chk("rst_put", RS_put_idx, 0);
    chk("rst_full", RS_full, 0);
    chk("rst_rob", ALU_ROB_idx, 0);
    #9 rst_n_in = 1'b1;
    step();

    // Ready path
    dis(1'b1, 32'd5, 1'b1, 32'd7, 4'd3);
    chk("rp_flag_early", ALU_issue_flag, 0);
    chk("rp_put_busy", RS_put_idx, 1);
    step();
    chk("rp_flag", ALU_issue_flag, 1);
    chk("rp_v1", ALU_V1, 5);
    chk("rp_v2", ALU_V2, 7);
    chk("rp_rob", ALU_ROB_idx, 3);
    chk("rp_op", ALU_op, 6'h21);
    chk("rp_imm", ALU_imm, 32'h1003);
    chk("rp_pc", ALU_PC, 32'h8003);
    chk("rp_put_free", RS_put_idx, 0);
    step();
    chk("rp_flag_off", ALU_issue_flag, 0);
    chk("rp_put", RS_put_idx, 0);
    chk("rp_hold_v1", ALU_V1, 5);

    // Wakeup from LSB
    dis(1'b0, 32'd2, 1'b1, 32'd11, 4'd4);
    step();
    chk("wk_wait1", ALU_issue_flag, 0);
    step();
    chk("wk_wait2", ALU_issue_flag, 0);
    LSB_cdb_flag = 1'b1; LSB_cdb_ROB_idx = 4'd2; LSB_cdb_value = 32'hDEAD;
    step();
    LSB_cdb_flag = 1'b0;
    chk("wk_not_yet", ALU_issue_flag, 0);
    step();
    chk("wk_flag", ALU_issue_flag, 1);
    chk("wk_v1", ALU_V1, 32'hDEAD);
    chk("wk_v2", ALU_V2, 11);
    chk("wk_rob", ALU_ROB_idx, 4);

    // Dispatch bypass from ALU
    ALU_cdb_flag = 1'b1; ALU_cdb_ROB_idx = 4'd9; ALU_cdb_value = 32'd42;
    dis(1'b1, 32'd1, 1'b0, 32'd9, 4'd5);
    chk("bp_flag_early", ALU_issue_flag, 0);
    step();
    chk("bp_flag", ALU_issue_flag, 1);
    chk("bp_v2", ALU_V2, 42);
    chk("bp_v1", ALU_V1, 1);
    chk("bp_rob", ALU_ROB_idx, 5);
    step();
    chk("bp_flag_off", ALU_issue_flag, 0);

    // Fill, overflow ignore, priority
    for (int i = 0; i < 16; i++) begin
      chk("fill_put", RS_put_idx, 32'(i));
      dis(1'b0, 32'(i), 1'b1, 32'h100 + 32'(i), 4'(i));
    end
    chk("fill_full", RS_full, 1);
    chk("fill_put0", RS_put_idx, 0);
    dis(1'b1, 32'h55, 1'b1, 32'h66, 4'd15);
    chk("ovf_full", RS_full, 1);
    chk("ovf_flag", ALU_issue_flag, 0);
    step();
    chk("ovf_no_issue", ALU_issue_flag, 0);
    ALU_cdb_flag = 1'b1; ALU_cdb_ROB_idx = 4'd7; ALU_cdb_value = 32'h70;
    LSB_cdb_flag = 1'b1; LSB_cdb_ROB_idx = 4'd3; LSB_cdb_value = 32'h30;
    step();
    ALU_cdb_flag = 1'b0; LSB_cdb_flag = 1'b0;
    chk("pr_wait", ALU_issue_flag, 0);
    chk("pr_full_still", RS_full, 1);
    step();
    chk("pr1_flag", ALU_issue_flag, 1);
    chk("pr1_rob", ALU_ROB_idx, 3);
    chk("pr1_v1", ALU_V1, 32'h30);
    chk("pr1_v2", ALU_V2, 32'h103);
    chk("pr1_full", RS_full, 0);
    chk("pr1_put", RS_put_idx, 3);
    step();
    chk("pr2_flag", ALU_issue_flag, 1);
    chk("pr2_rob", ALU_ROB_idx, 7);
    chk("pr2_v1", ALU_V1, 32'h70);
    chk("pr2_put", RS_put_idx, 3);
    step();
    chk("pr3_flag", ALU_issue_flag, 0);

    // Flush with a pending candidate
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    chk("fl0_full", RS_full, 0);
    chk("fl0_put", RS_put_idx, 0);
    for (int i = 0; i < 4; i++) dis(1'b0, 32'd12, 1'b1, 32'd0, 4'(i));
    dis(1'b1, 32'h77, 1'b1, 32'h78, 4'd10);
    chk("fl_put5", RS_put_idx, 5);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    chk("fl_flag", ALU_issue_flag, 0);
    chk("fl_put", RS_put_idx, 0);
    chk("fl_full", RS_full, 0);
    step();
    chk("fl_flag_after", ALU_issue_flag, 0);

    // Freeze with rdy_in low
    dis(1'b1, 32'h99, 1'b1, 32'h98, 4'd9);
    rdy_in = 1'b0;
    step();
    chk("frz_flag1", ALU_issue_flag, 0);
    chk("frz_put1", RS_put_idx, 1);
    step();
    chk("frz_flag2", ALU_issue_flag, 0);
    chk("frz_put2", RS_put_idx, 1);
    rdy_in = 1'b1;
    step();
    chk("frz_rel_flag", ALU_issue_flag, 1);
    chk("frz_rel_rob", ALU_ROB_idx, 9);
    chk("frz_rel_v1", ALU_V1, 32'h99);

    // Asynchronous reset mid-cycle
    #2 rst_n_in = 1'b0;
    #1;
    chk("ar_flag", ALU_issue_flag, 0);
    chk("ar_rob", ALU_ROB_idx, 0);
    chk("ar_v1", ALU_V1, 0);
    chk("ar_put", RS_put_idx, 0);
    chk("ar_full", RS_full, 0);
    rst_n_in = 1'b1;
    step();
    chk("ar_after", ALU_issue_flag, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Unified reservation station for the Tomasulo core. It holds non-store instructions sent by `dispatch`, snoops the ALU and LSB common data buses to resolve pending operands, and issues the lowest-index fully ready entry to the ALU one instruction per cycle. It returns free-slot and full status to `dispatch`.

## Interface
- `RS_SIZE`, 16: number of entries.
- `RS_WIDTH`, 4: entry index width; RS_SIZE = 2^RS_WIDTH.
- `ROB_WIDTH`, 4: ROB tag width.

- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global enable; low freezes all state.
- `clear_in`  in  1  mispredict flush.
- `Dis_flag`  in  1  dispatch writes one entry this cycle.
- `Dis_op`  in  6  opcode.
- `Dis_imm`  in  32  immediate.
- `Dis_PC`  in  32  instruction PC.
- `Dis_ROB_idx`  in  ROB_WIDTH  destination ROB tag.
- `Dis_R1` / `Dis_R2`  in  1 each  operand ready. When low, `Dis_Vx[ROB_WIDTH-1:0]` is the producing ROB tag.
- `Dis_V1` / `Dis_V2`  in  32 each  operand value or tag.
- `ALU_cdb_flag`, `ALU_cdb_ROB_idx`, `ALU_cdb_value`  in  1 / ROB_WIDTH / 32  ALU broadcast.
- `LSB_cdb_flag`, `LSB_cdb_ROB_idx`, `LSB_cdb_value`  in  1 / ROB_WIDTH / 32  LSB broadcast.
- `RS_put_idx`  out  RS_WIDTH  lowest free entry index; combinational from registered state.
- `RS_full`  out  1  no free entry; combinational.
- `ALU_issue_flag`  out  1  registered; issue valid this cycle.
- `ALU_op`, `ALU_V1`, `ALU_V2`, `ALU_imm`, `ALU_PC`, `ALU_ROB_idx`  out  6 / 32 / 32 / 32 / 32 / ROB_WIDTH  registered issue payload.

## Operation
- Each entry holds: busy, op, imm, PC, ROB tag, R1, V1, Q1, R2, V2, Q2.
- **Free slot:** `RS_put_idx` is the lowest index with busy=0. If every entry is busy, `RS_full`=1 and `RS_put_idx`=0.
- **Allocate:** when `Dis_flag` is high and `RS_full` is low, the entry at `RS_put_idx` is written and set busy.
  - For each operand with R=0, Q takes `Dis_Vx[ROB_WIDTH-1:0]`.
  - `Dis_flag` while full is a protocol violation. It is ignored and no entry is overwritten.
- **Dispatch bypass:** if an incoming operand has R=0 and its tag matches a valid CDB tag in the same cycle, the entry is written with the CDB value and R=1.
- **Wakeup:** every cycle, each busy entry with Rx=0 whose Qx equals a valid CDB tag captures that CDB's value and sets Rx=1.
  - Both operands may wake in the same cycle, from the same bus or from different buses.
  - If both buses carry the same tag, ALU has priority. Upstream should never produce this case.
- **Select:** the candidate is the lowest-index entry that is busy with R1=R2=1, using registered state.
  - An entry that wakes or is allocated in cycle N is not a candidate until cycle N+1.
- **Issue:** on each edge, if a candidate exists:
  - the issue registers load its payload and `ALU_issue_flag`=1;
  - the entry's busy bit clears.
  - With no candidate, `ALU_issue_flag`=0 and the payload holds its last value.
- **Same-slot reuse:** an entry cleared by issue on edge N is visible as free right after edge N.
- **Flush:** `clear_in` high at an edge clears every busy bit and `ALU_issue_flag`. It overrides allocate, wakeup and issue on that edge.
- **rdy_in low:** no register changes. Downstream blocks are stalled by the same `rdy_in`.
- **Reset** (`rst_n_in` low, asynchronous):
  - all busy, R and Q bits are 0;
  - all issue outputs are 0;
  - `RS_full`=0 and `RS_put_idx`=0 follow from this.
- **Widths:** tags compare on ROB_WIDTH bits only. Values are stored unmodified, with no arithmetic.

## Timing
- Dispatch with both operands ready at edge N gives `ALU_issue_flag`=1 in cycle N+1, i.e. after edge N+1. Minimum latency is one cycle in the RS.
- Operand tag broadcast at edge N (CDB valid in cycle N-1..N): the entry becomes a candidate for edge N+1.
- Throughput is one issue per cycle. Allocate and issue may target the same cycle; they never target the same slot, because allocation only uses non-busy entries.
- `RS_full` and `RS_put_idx` settle within the cycle after each edge, so `dispatch` may sample them combinationally.

## Test plan
- **Ready path:** reset, then dispatch ADD with R1=R2=1, V1=5, V2=7, ROB=3.
  - Next cycle: `ALU_issue_flag`=1, V1=5, V2=7, ROB_idx=3.
  - Following cycle: flag=0 and `RS_put_idx`=0.
- **Wakeup:** dispatch with R1=0 tag 2, R2=1.
  - Then drive `LSB_cdb` tag 2, value 0xDEAD.
  - Issue occurs exactly one cycle later with V1=0xDEAD; there is no issue before the broadcast.
- **Dispatch bypass:** dispatch R2=0 tag 9 in the same cycle `ALU_cdb` broadcasts tag 9, value 42.
  - The entry issues the next cycle with V2=42.
- **Fill and priority:** dispatch 16 non-ready entries.
  - `RS_full`=1; a 17th `Dis_flag` changes nothing.
  - Wake entries 7 and 3 together: issue 3 first, then 7 on consecutive cycles.
  - After the first issue, `RS_full`=0 and `RS_put_idx`=3.
- **Flush and freeze:** with 5 busy entries and one candidate, assert `clear_in` → no issue, `RS_put_idx`=0, `RS_full`=0.
  - Separately, with `rdy_in`=0 and a ready entry present, no issue occurs and the state holds.
- **Async reset:** drop `rst_n_in` mid-cycle while `ALU_issue_flag`=1.
  - Outputs go to 0 immediately, without waiting for a clock edge.
